muldiv_sched: RTL and testbench

Sequencer and arbiter for the single shared iterative multiply/divide unit used by M-extension instructions leaving decode. It accepts one MUL or DIV issue at a time and produces the `mul_ready`/`div_ready` flags that decode folds into its hazard stall. It drives start, operation, select and hold to the shared unit, counts its fixed latency, aborts on flush or trap, and captures the result with its destination tag for EX/MEM forwarding and writeback.

---
 rtl/muldiv_sched_if.sv | 41 ++++
 rtl/muldiv_sched.sv | 146 ++++++++++++++
 tb/tb_muldiv_sched.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sched_if.sv
// Issue, control and result signals between decode, muldiv_sched and the shared mul/div unit.
// master drives the issue side and unit_result; slave is the sequencer.
interface muldiv_sched_if;
    logic        issue_valid;
    logic        mul_inst;
    logic        div_inst;
    logic [2:0]  mulsel;
    logic [2:0]  divsel;
    logic [4:0]  issue_rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        hold;
    logic        flush;
    logic [31:0] unit_result;

    logic        unit_start;
    logic        unit_op;
    logic [2:0]  unit_sel;
    logic        unit_hold;
    logic        unit_abort;
    logic        mul_ready;
    logic        div_ready;
    logic        busy;
    logic        res_valid;
    logic [31:0] result;
    logic [4:0]  res_rd;

    modport master (
        output issue_valid, mul_inst, div_inst, mulsel, divsel, issue_rd,
        output rs1_val, rs2_val, hold, flush, unit_result,
        input  unit_start, unit_op, unit_sel, unit_hold, unit_abort,
        input  mul_ready, div_ready, busy, res_valid, result, res_rd
    );

    modport slave (
        input  issue_valid, mul_inst, div_inst, mulsel, divsel, issue_rd,
        input  rs1_val, rs2_val, hold, flush, unit_result,
        output unit_start, unit_op, unit_sel, unit_hold, unit_abort,
        output mul_ready, div_ready, busy, res_valid, result, res_rd
    );
endinterface

// File: rtl/muldiv_sched.sv
// Sequencer/arbiter for the shared iterative mul/div unit: issue, latency count, abort, capture.
// Optional MULDIV_DIV0_FAST_EN: divide by zero completes in IDLE without starting the unit.
module muldiv_sched #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 33
) (
    input logic           clk,
    input logic           Rst,
    muldiv_sched_if.slave bus
);
    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StMulRun = 2'd1;
    localparam logic [1:0] StDivRun = 2'd2;

    logic [1:0]      r_state,     w_state_d;
    logic [CntW-1:0] r_cnt,       w_cnt_d;
    logic [4:0]      r_tag,       w_tag_d;
    logic            r_start,     w_start_d;
    logic            r_abort,     w_abort_d;
    logic            r_op,        w_op_d;
    logic [2:0]      r_sel,       w_sel_d;
    logic            r_res_valid, w_res_valid_d;
    logic [31:0]     r_result,    w_result_d;
    logic [4:0]      r_res_rd,    w_res_rd_d;
    logic            r_ready;
    logic            r_busy;

    logic            w_issue_ok;
    logic            w_issue_mul;
    logic            w_issue_div;
    logic            w_rs2_zero;
    logic            w_div0_fast;
    logic [31:0]     w_div0_result;

    assign w_issue_ok  = bus.issue_valid & ~bus.flush & ~bus.hold;
    assign w_issue_mul = w_issue_ok & bus.mul_inst;
    // MUL wins when both class bits are set.
    assign w_issue_div = w_issue_ok & bus.div_inst & ~bus.mul_inst;

    assign w_rs2_zero    = (bus.rs2_val == 32'd0);
    assign w_div0_result = bus.divsel[1] ? bus.rs1_val : 32'hFFFF_FFFF;
`ifdef MULDIV_DIV0_FAST_EN
    assign w_div0_fast   = w_rs2_zero;
`else
    assign w_div0_fast   = w_rs2_zero & 1'b0;
`endif

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_tag_d       = r_tag;
        w_start_d     = 1'b0;
        w_abort_d     = 1'b0;
        w_op_d        = r_op;
        w_sel_d       = r_sel;
        w_res_valid_d = 1'b0;
        w_result_d    = r_result;
        w_res_rd_d    = r_res_rd;

        case (r_state)
            StIdle: begin
                if (w_issue_mul) begin
                    w_state_d = StMulRun;
                    w_cnt_d   = CntW'(MUL_LAT - 1);
                    w_tag_d   = bus.issue_rd;
                    w_start_d = 1'b1;
                    w_op_d    = 1'b0;
                    w_sel_d   = bus.mulsel;
                end else if (w_issue_div && w_div0_fast) begin
                    w_res_valid_d = 1'b1;
                    w_result_d    = w_div0_result;
                    w_res_rd_d    = bus.issue_rd;
                end else if (w_issue_div) begin
                    w_state_d = StDivRun;
                    w_cnt_d   = CntW'(DIV_LAT - 1);
                    w_tag_d   = bus.issue_rd;
                    w_start_d = 1'b1;
                    w_op_d    = 1'b1;
                    w_sel_d   = bus.divsel;
                end
            end
            default: begin
                // Flush outranks both completion and hold.
                if (bus.flush) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                    w_abort_d = 1'b1;
                end else if (!bus.hold) begin
                    if (r_cnt != '0) begin
                        w_cnt_d = r_cnt - 1'b1;
                    end else begin
                        w_state_d     = StIdle;
                        w_res_valid_d = 1'b1;
                        w_result_d    = bus.unit_result;
                        w_res_rd_d    = r_tag;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_tag       <= '0;
            r_start     <= 1'b0;
            r_abort     <= 1'b0;
            r_op        <= 1'b0;
            r_sel       <= '0;
            r_res_valid <= 1'b0;
            r_result    <= '0;
            r_res_rd    <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_tag       <= w_tag_d;
            r_start     <= w_start_d;
            r_abort     <= w_abort_d;
            r_op        <= w_op_d;
            r_sel       <= w_sel_d;
            r_res_valid <= w_res_valid_d;
            r_result    <= w_result_d;
            r_res_rd    <= w_res_rd_d;
            r_ready     <= (w_state_d == StIdle);
            r_busy      <= (w_state_d != StIdle);
        end
    end

    assign bus.unit_start = r_start;
    assign bus.unit_op    = r_op;
    assign bus.unit_sel   = r_sel;
    assign bus.unit_hold  = bus.hold & (r_state != StIdle);
    assign bus.unit_abort = r_abort;
    assign bus.mul_ready  = r_ready;
    assign bus.div_ready  = r_ready;
    assign bus.busy       = r_busy;
    assign bus.res_valid  = r_res_valid;
    assign bus.result     = r_result;
    assign bus.res_rd     = r_res_rd;
endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: stimulus pushes expected results, a negedge monitor pops them.
// Honours MULDIV_DIV0_FAST_EN for the divide-by-zero vectors.
module tb_muldiv_sched;
    localparam int MulLat = 4;
    localparam int DivLat = 33;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        int          cycle;
    } exp_t;

    logic clk = 1'b0;
    logic Rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    muldiv_sched_if bus ();

    muldiv_sched #(.MUL_LAT(MulLat), .DIV_LAT(DivLat)) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!Rst && bus.res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("res_valid_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", bus.result, e.result);
                check("res_rd", {27'd0, bus.res_rd}, {27'd0, e.rd});
                check("res_cycle", cyc, e.cycle);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic m, input logic d, input logic [2:0] ms, input logic [2:0] ds,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        bus.issue_valid = 1'b1;
        bus.mul_inst    = m;
        bus.div_inst    = d;
        bus.mulsel      = ms;
        bus.divsel      = ds;
        bus.issue_rd    = rd;
        bus.rs1_val     = a;
        bus.rs2_val     = b;
        step();
        bus.issue_valid = 1'b0;
        bus.mul_inst    = 1'b0;
        bus.div_inst    = 1'b0;
    endtask

    task automatic push(input logic [31:0] r, input logic [4:0] rd, input int c);
        exp_t e;
        e.result = r;
        e.rd     = rd;
        e.cycle  = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (bus.busy === 1'b1 && n < max) begin
            step();
            n++;
        end
        check("wait_idle_timeout", {31'd0, bus.busy}, 32'd0);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mul_ready"}, {31'd0, bus.mul_ready}, 32'd1);
        check({tag, "_div_ready"}, {31'd0, bus.div_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_start"}, {31'd0, bus.unit_start}, 32'd0);
        check({tag, "_abort"}, {31'd0, bus.unit_abort}, 32'd0);
        check({tag, "_res_valid"}, {31'd0, bus.res_valid}, 32'd0);
        check({tag, "_unit_op"}, {31'd0, bus.unit_op}, 32'd0);
        check({tag, "_unit_sel"}, {29'd0, bus.unit_sel}, 32'd0);
        check({tag, "_result"}, bus.result, 32'd0);
        check({tag, "_res_rd"}, {27'd0, bus.res_rd}, 32'd0);
    endtask

    initial begin
        int e;
        bus.issue_valid = 1'b0;
        bus.mul_inst    = 1'b0;
        bus.div_inst    = 1'b0;
        bus.mulsel      = 3'd0;
        bus.divsel      = 3'd0;
        bus.issue_rd    = 5'd0;
        bus.rs1_val     = 32'd0;
        bus.rs2_val     = 32'd0;
        bus.hold        = 1'b0;
        bus.flush       = 1'b0;
        bus.unit_result = 32'd0;
        step();
        step();
        Rst = 1'b0;
        check_reset_outputs("reset");

        // Plain multiply.
        bus.unit_result = 32'h0000_0C00;
        push(32'h0000_0C00, 5'd5, cyc + 1 + MulLat);
        issue(1'b1, 1'b0, 3'b001, 3'b000, 5'd5, 32'd3, 32'h400);
        check("mul_start", {31'd0, bus.unit_start}, 32'd1);
        check("mul_op", {31'd0, bus.unit_op}, 32'd0);
        check("mul_sel", {29'd0, bus.unit_sel}, 32'd1);
        for (int i = 0; i < MulLat; i++) begin
            check("mul_ready_low", {31'd0, bus.mul_ready}, 32'd0);
            check("div_ready_low", {31'd0, bus.div_ready}, 32'd0);
            step();
        end
        check("mul_ready_back", {31'd0, bus.mul_ready}, 32'd1);
        check("mul_start_gone", {31'd0, bus.unit_start}, 32'd0);
        step();

        // Hold or flush in IDLE suppresses issue; hold does not reach the unit in IDLE.
        bus.hold = 1'b1;
        #1 check("idle_unit_hold", {31'd0, bus.unit_hold}, 32'd0);
        issue(1'b1, 1'b0, 3'b000, 3'b000, 5'd1, 32'd0, 32'd0);
        check("hold_blocks_issue", {31'd0, bus.unit_start}, 32'd0);
        bus.hold  = 1'b0;
        bus.flush = 1'b1;
        issue(1'b0, 1'b1, 3'b000, 3'b000, 5'd1, 32'd0, 32'd1);
        check("flush_blocks_issue", {31'd0, bus.busy}, 32'd0);
        bus.flush = 1'b0;

        // Divide with 3 hold cycles.
        bus.unit_result = 32'hDEAD_BEEF;
        push(32'hDEAD_BEEF, 5'd9, cyc + 1 + DivLat + 3);
        issue(1'b0, 1'b1, 3'b000, 3'b011, 5'd9, 32'd100, 32'd7);
        check("div_start", {31'd0, bus.unit_start}, 32'd1);
        check("div_op", {31'd0, bus.unit_op}, 32'd1);
        check("div_sel", {29'd0, bus.unit_sel}, 32'd3);
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            bus.hold = 1'b1;
            #1 check("run_unit_hold", {31'd0, bus.unit_hold}, 32'd1);
            step();
        end
        bus.hold = 1'b0;
        #1 check("run_unit_hold_off", {31'd0, bus.unit_hold}, 32'd0);
        wait_idle(60);

        // Flush 10 cycles into a divide.
        bus.unit_result = 32'h0000_5555;
        issue(1'b0, 1'b1, 3'b000, 3'b001, 5'd3, 32'd50, 32'd5);
        e = cyc;
        while (cyc < e + 9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("abort_pulse", {31'd0, bus.unit_abort}, 32'd1);
        check("abort_ready", {31'd0, bus.div_ready}, 32'd1);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_result_kept", bus.result, 32'hDEAD_BEEF);
        step();
        check("abort_one_cycle", {31'd0, bus.unit_abort}, 32'd0);
        repeat (40) step();

        // Back-to-back multiply issued in the res_valid cycle.
        bus.unit_result = 32'h0C00_0001;
        push(32'h0C00_0001, 5'd7, cyc + 1 + MulLat);
        issue(1'b1, 1'b0, 3'b000, 3'b000, 5'd7, 32'd1, 32'd1);
        e = cyc;
        while (cyc < e + MulLat) step();
        check("b2b_res_valid", {31'd0, bus.res_valid}, 32'd1);
        bus.unit_result = 32'h0000_2222;
        push(32'h0000_2222, 5'd8, cyc + 1 + MulLat);
        issue(1'b1, 1'b0, 3'b010, 3'b000, 5'd8, 32'd2, 32'd2);
        check("b2b_start", {31'd0, bus.unit_start}, 32'd1);
        wait_idle(20);

        // Divide by zero, quotient then remainder.
`ifdef MULDIV_DIV0_FAST_EN
        push(32'hFFFF_FFFF, 5'd10, cyc + 1);
        issue(1'b0, 1'b1, 3'b000, 3'b000, 5'd10, 32'h1234, 32'd0);
        check("div0_q_no_start", {31'd0, bus.unit_start}, 32'd0);
        check("div0_q_idle", {31'd0, bus.busy}, 32'd0);
        step();
        push(32'h0000_1234, 5'd11, cyc + 1);
        issue(1'b0, 1'b1, 3'b000, 3'b010, 5'd11, 32'h1234, 32'd0);
        check("div0_r_no_start", {31'd0, bus.unit_start}, 32'd0);
        step();
`else
        bus.unit_result = 32'hFFFF_FFFF;
        push(32'hFFFF_FFFF, 5'd10, cyc + 1 + DivLat);
        issue(1'b0, 1'b1, 3'b000, 3'b000, 5'd10, 32'h1234, 32'd0);
        check("div0_q_start", {31'd0, bus.unit_start}, 32'd1);
        wait_idle(60);
        bus.unit_result = 32'h0000_0BAD;
        push(32'h0000_0BAD, 5'd11, cyc + 1 + DivLat);
        issue(1'b0, 1'b1, 3'b000, 3'b010, 5'd11, 32'h1234, 32'd0);
        check("div0_r_start", {31'd0, bus.unit_start}, 32'd1);
        wait_idle(60);
`endif

        // Reset during MUL_RUN.
        issue(1'b1, 1'b0, 3'b111, 3'b000, 5'd1, 32'd0, 32'd0);
        step();
        Rst = 1'b1;
        step();
        check_reset_outputs("midreset");
        Rst = 1'b0;
        step();

        // Simultaneous MUL and DIV: MUL wins.
        bus.unit_result = 32'h0000_0777;
        push(32'h0000_0777, 5'd12, cyc + 1 + MulLat);
        issue(1'b1, 1'b1, 3'b010, 3'b101, 5'd12, 32'd9, 32'd9);
        check("both_op", {31'd0, bus.unit_op}, 32'd0);
        check("both_sel", {29'd0, bus.unit_sel}, 32'd2);
        check("both_start", {31'd0, bus.unit_start}, 32'd1);
        wait_idle(20);

        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
